network_rr_mux: RTL and testbench

Parametrised N-channel to 1-channel merge for the network handshake bus (id, val, valid, ready). Multiple producers drive the block, which selects among them with a fair round-robin arbiter and forwards one beat per cycle through a registered skid-buffer output stage. A source-index sideband identifies which producer each beat came from. The block sits between multiple network producers (e.g. per-lane compute units) and a single network consumer. It also breaks the combinational ready path between them.

---
 rtl/network_rr_mux.sv | 121 ++++++++++++
 tb/tb_network_rr_mux.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/network_rr_mux.sv
// rtl/network_rr_mux.sv - N-to-1 round-robin merge with registered skid-buffer output stage
// Ready toward producers depends only on s_valid and registered state, never on m_ready.
module network_rr_mux #(
  parameter int IN_WIDTH = 32,
  parameter int ID_WIDTH = 32,
  parameter int N_CH     = 4,
  parameter int SRC_W    = $clog2(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH*ID_WIDTH-1:0]   s_id,
  input  logic [N_CH*IN_WIDTH-1:0]   s_val,
  input  logic [N_CH-1:0]            s_valid,
  output logic [N_CH-1:0]            s_ready,
  output logic [ID_WIDTH-1:0]        m_id,
  output logic [IN_WIDTH-1:0]        m_val,
  output logic [SRC_W-1:0]           m_src,
  output logic                       m_valid,
  input  logic                       m_ready
);

  logic [SRC_W-1:0]    r_last_grant;
  logic [ID_WIDTH-1:0] r_m_id;
  logic [IN_WIDTH-1:0] r_m_val;
  logic [SRC_W-1:0]    r_m_src;
  logic                r_m_valid;
  logic [ID_WIDTH-1:0] r_skid_id;
  logic [IN_WIDTH-1:0] r_skid_val;
  logic [SRC_W-1:0]    r_skid_src;
  logic                r_skid_full;

  logic                w_grant_vld;
  logic [SRC_W-1:0]    w_grant;
  logic [SRC_W-1:0]    w_cand;
  logic [ID_WIDTH-1:0] w_sel_id;
  logic [IN_WIDTH-1:0] w_sel_val;
  logic                w_acc;
  logic                w_pop;

  // Search starts one past the last granted channel and wraps, so the winner rotates.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_cand      = '0;
    for (int i = 1; i <= N_CH; i++) begin
      w_cand = SRC_W'((int'(r_last_grant) + i) % N_CH);
      if (!w_grant_vld && s_valid[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_cand;
      end
    end
  end

  always_comb begin
    s_ready = '0;
    if (w_grant_vld && !r_skid_full && !rst) begin
      s_ready[w_grant] = 1'b1;
    end
  end

  always_comb begin
    w_sel_id  = '0;
    w_sel_val = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_grant == SRC_W'(k)) begin
        w_sel_id  = s_id[k*ID_WIDTH +: ID_WIDTH];
        w_sel_val = s_val[k*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  assign w_acc = |s_ready;
  assign w_pop = r_m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= SRC_W'(N_CH - 1);
      r_m_id       <= '0;
      r_m_val      <= '0;
      r_m_src      <= '0;
      r_m_valid    <= 1'b0;
      r_skid_id    <= '0;
      r_skid_val   <= '0;
      r_skid_src   <= '0;
      r_skid_full  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_last_grant <= w_grant;
      end
      if (r_skid_full) begin
        // s_ready is all zero here, so only the skid-to-main move can happen.
        if (w_pop) begin
          r_m_id      <= r_skid_id;
          r_m_val     <= r_skid_val;
          r_m_src     <= r_skid_src;
          r_skid_full <= 1'b0;
        end
      end else if (w_acc) begin
        if (!r_m_valid || w_pop) begin
          r_m_id    <= w_sel_id;
          r_m_val   <= w_sel_val;
          r_m_src   <= w_grant;
          r_m_valid <= 1'b1;
        end else begin
          r_skid_id   <= w_sel_id;
          r_skid_val  <= w_sel_val;
          r_skid_src  <= w_grant;
          r_skid_full <= 1'b1;
        end
      end else if (w_pop) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_id    = r_m_id;
  assign m_val   = r_m_val;
  assign m_src   = r_m_src;
  assign m_valid = r_m_valid;

endmodule

// File: tb/tb_network_rr_mux.sv
// tb/tb_network_rr_mux.sv - scoreboard bench for network_rr_mux with an occupancy-based reference model
module tb_network_rr_mux;
  localparam int N  = 4;
  localparam int IW = 32;
  localparam int DW = 32;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] s_id;
  logic [N*IW-1:0] s_val;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic [DW-1:0]   m_id;
  logic [IW-1:0]   m_val;
  logic [SW-1:0]   m_src;
  logic            m_valid;
  logic            m_ready;

  network_rr_mux #(.IN_WIDTH(IW), .ID_WIDTH(DW), .N_CH(N)) dut (
    .clk(clk), .rst(rst), .s_id(s_id), .s_val(s_val), .s_valid(s_valid),
    .s_ready(s_ready), .m_id(m_id), .m_val(m_val), .m_src(m_src),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] id;
    logic [IW-1:0] val;
    int            src;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: occupancy count (0..2) plus the channel served last.
  int occ  = 0;
  int last = N - 1;

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic [N-1:0] hs;
    int g;
    if (rst) begin
      chk("s_ready_in_reset", 64'(s_ready), 64'(0));
      occ  = 0;
      last = N - 1;
      sb.delete();
    end else begin
      chk("m_valid_vs_occupancy", 64'(m_valid), 64'(occ > 0));
      exp_rdy = '0;
      if (occ < 2) begin
        for (int i = 1; i <= N; i++) begin
          if (exp_rdy == '0 && s_valid[(last + i) % N]) exp_rdy[(last + i) % N] = 1'b1;
        end
      end
      chk("s_ready_grant", 64'(s_ready), 64'(exp_rdy));
      hs = s_ready & s_valid;
      g  = -1;
      for (int k = 0; k < N; k++) if (hs[k]) g = k;
      if (g >= 0) begin
        sb.push_back('{id: s_id[g*DW +: DW], val: s_val[g*IW +: IW], src: g});
        last = g;
        occ++;
      end
      if (m_valid && m_ready) occ--;
    end
  end

  logic          prev_rst = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] hold_id;
  logic [IW-1:0] hold_val;
  logic [SW-1:0] hold_src;

  always @(negedge clk) begin
    beat_t b;
    if (!rst && prev_rst) begin
      chk("post_reset_m_valid", 64'(m_valid), 64'(0));
      chk("post_reset_m_id", 64'(m_id), 64'(0));
      chk("post_reset_m_val", 64'(m_val), 64'(0));
      chk("post_reset_m_src", 64'(m_src), 64'(0));
    end
    if (!rst && prev_stall) begin
      chk("stall_m_valid", 64'(m_valid), 64'(1));
      chk("stall_m_id", 64'(m_id), 64'(hold_id));
      chk("stall_m_val", 64'(m_val), 64'(hold_val));
      chk("stall_m_src", 64'(m_src), 64'(hold_src));
    end
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat_src", 64'(m_src), 64'hFFFF);
      end else begin
        b = sb.pop_front();
        chk("beat_id", 64'(m_id), 64'(b.id));
        chk("beat_val", 64'(m_val), 64'(b.val));
        chk("beat_src", 64'(m_src), 64'(b.src));
      end
    end
    prev_rst   = rst;
    prev_stall = !rst && m_valid && !m_ready;
    hold_id    = m_id;
    hold_val   = m_val;
    hold_src   = m_src;
  end

  // Producer / consumer driver
  int rem[N];
  int seq[N];
  int mr_mode = 1;
  int pcyc = 0;
  bit seq_mode = 1'b0;
  bit rnd_mode = 1'b0;

  task automatic step();
    logic [N-1:0] acc_v;
    @(negedge clk);
    acc_v = s_valid & s_ready & {N{!rst}};
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc_v[k]) begin
        s_valid[k] = 1'b0;
        rem[k]--;
      end
      if (rnd_mode && rem[k] == 0 && $urandom_range(0, 2) == 0) rem[k] = $urandom_range(1, 3);
      if (!s_valid[k] && rem[k] > 0) begin
        seq[k]++;
        s_id[k*DW +: DW]  = $urandom;
        s_val[k*IW +: IW] = seq_mode ? IW'(seq[k]) : IW'($urandom);
        s_valid[k]        = 1'b1;
      end
    end
    pcyc++;
    case (mr_mode)
      0: m_ready = 1'b0;
      1: m_ready = 1'b1;
      2: m_ready = (pcyc % 4 == 0) || (pcyc % 4 == 3);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic drain();
    int budget = 200;
    mr_mode  = 1;
    rnd_mode = 1'b0;
    while (budget > 0 && (s_valid != '0 || m_valid)) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got s_valid=0x%0h m_valid=%0b, expected idle", s_valid, m_valid);
    end
  endtask

  task automatic set_rem(input int r0, input int r1, input int r2, input int r3);
    rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
  endtask

  initial begin
    rst     = 1'b1;
    s_id    = '0;
    s_val   = '0;
    s_valid = '0;
    m_ready = 1'b0;
    set_rem(0, 0, 0, 0);
    for (int k = 0; k < N; k++) seq[k] = 0;
    mr_mode = 0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // single beat on channel 2
    mr_mode = 1;
    set_rem(0, 0, 1, 0);
    s_id[2*DW +: DW]  = 32'h10;
    s_val[2*IW +: IW] = 32'hAAAA_0001;
    s_valid[2]        = 1'b1;
    rem[2]            = 1;
    repeat (4) step();
    drain();

    // all channels continuously valid
    set_rem(3, 3, 3, 3);
    repeat (14) step();
    drain();

    // skid fill under backpressure, then release
    mr_mode = 0;
    set_rem(3, 3, 0, 0);
    repeat (6) step();
    drain();

    // stall stability: channel 3 streams 1..8 with m_ready 1,0,0,1
    seq_mode = 1'b1;
    seq[3]   = 0;
    pcyc     = 0;
    mr_mode  = 2;
    set_rem(0, 0, 0, 8);
    repeat (30) step();
    seq_mode = 1'b0;
    drain();

    // reset while both output registers hold data
    mr_mode = 0;
    set_rem(2, 2, 2, 2);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mr_mode = 1;
    repeat (3) step();
    drain();

    // sparse: only channels 1 and 3
    set_rem(0, 4, 0, 4);
    repeat (10) step();
    drain();

    // randomized traffic and backpressure
    rnd_mode = 1'b1;
    mr_mode  = 3;
    repeat (400) step();
    drain();

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
